// File: rtl/sram_port0_master.sv
// sram_port0_master
// Request-side controller for the RW port of the 32x256 data SRAM macro.
// Accepts one byte-addressed load/store at a time, drives the macro's
// active-low controls, byte mask and lane-replicated write data, and
// returns an extended, single-cycle load response.
`timescale 1ns/1ps

module sram_port0_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    // core-side request
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    // core-side response
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // macro port 0
    output logic                    csb0,
    output logic                    web0,
    output logic [NUM_WMASKS-1:0]   wmask0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH-1:0]   dout0
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DATA   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // A request is misaligned when its size does not divide its byte offset,
    // or when the size code is the reserved value.
    function automatic logic f_misaligned(input logic [1:0] size,
                                          input logic [1:0] lo);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lo[0];
            2'd2:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [3:0] f_wmask(input logic [1:0] size,
                                           input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << lo;
            2'd1:    m = 4'b0011 << {lo[1], 1'b0};
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-justified store data across every lane it may occupy,
    // so the byte mask alone selects the destination.
    function automatic logic [31:0] f_wdata(input logic [1:0]  size,
                                            input logic [31:0] w);
        logic [31:0] d;
        case (size)
            2'd0:    d = {4{w[7:0]}};
            2'd1:    d = {2{w[15:0]}};
            2'd2:    d = w;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/half out of the macro word and extend it.
    function automatic logic [31:0] f_extract(input logic [1:0]  size,
                                              input logic [1:0]  lo,
                                              input logic        uns,
                                              input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    r = {{24{~uns & b[7]}}, b};
            2'd1:    r = {{16{~uns & h[15]}}, h};
            2'd2:    r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q,     state_d;
    logic                    we_q,        we_d;
    logic [1:0]              lane_q,      lane_d;
    logic [1:0]              size_q,      size_d;
    logic                    unsigned_q,  unsigned_d;

    logic                    csb0_q,      csb0_d;
    logic                    web0_q,      web0_d;
    logic [NUM_WMASKS-1:0]   wmask0_q,    wmask0_d;
    logic [ADDR_WIDTH-1:0]   addr0_q,     addr0_d;
    logic [DATA_WIDTH-1:0]   din0_q,      din0_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q,   rsp_err_d;

    logic                    req_mis_s;

    assign req_mis_s = f_misaligned(req_size, req_addr[1:0]);

    // Next-state and next-output logic; macro strobes default to inactive
    // so they only assert for the single ACCESS cycle.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        lane_d      = lane_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        csb0_d      = 1'b1;
        web0_d      = 1'b1;
        wmask0_d    = {NUM_WMASKS{1'b0}};
        addr0_d     = addr0_q;
        din0_d      = din0_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    lane_d     = req_addr[1:0];
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    if (req_mis_s) begin
                        // Reject without touching the macro.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        state_d = ST_ACCESS;
                        csb0_d  = 1'b0;
                        web0_d  = ~req_we;
                        addr0_d = req_addr[ADDR_WIDTH+1:2];
                        if (req_we) begin
                            wmask0_d = f_wmask(req_size, req_addr[1:0]);
                            din0_d   = f_wdata(req_size, req_wdata);
                        end else begin
                            wmask0_d = {NUM_WMASKS{1'b0}};
                            din0_d   = {DATA_WIDTH{1'b0}};
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                // The macro captures the command at the edge ending this cycle.
                if (we_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = {DATA_WIDTH{1'b0}};
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                // dout0 is stable through the edge ending this cycle.
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = f_extract(size_q, lane_q, unsigned_q, dout0);
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset abandons any
    // transaction in flight without issuing a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            wmask0_q    <= {NUM_WMASKS{1'b0}};
            addr0_q     <= {ADDR_WIDTH{1'b0}};
            din0_q      <= {DATA_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            wmask0_q    <= wmask0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign csb0      = csb0_q;
    assign web0      = web0_q;
    assign wmask0    = wmask0_q;
    assign addr0     = addr0_q;
    assign din0      = din0_q;

endmodule

// File: tb/tb_sram_port0_master.sv
// Testbench for sram_port0_master: emulates the SRAM macro, drives directed
// and random requests, and compares every cycle against a transaction-level
// model built on a byte-addressed memory.
`timescale 1ns/1ps

module tb_sram_port0_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [9:0]  req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0, dout0;

    sram_port0_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WMASKS(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(dout0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- SRAM macro emulation (word array, masked write) -------
    logic [31:0] sram [256];
    bit          m_pend, m_we;
    logic [7:0]  m_addr;
    logic [3:0]  m_mask;
    logic [31:0] m_din;

    always @(posedge clk) begin
        if (csb0 === 1'b0) begin
            m_pend = 1'b1; m_we = !web0; m_addr = addr0; m_mask = wmask0; m_din = din0;
        end else begin
            m_pend = 1'b0;
        end
    end

    // Writes and reads resolve on the falling edge; otherwise dout0 is junk.
    always @(negedge clk) begin
        if (m_pend && m_we)
            for (int i = 0; i < 4; i++)
                if (m_mask[i]) sram[m_addr][8*i +: 8] = m_din[8*i +: 8];
        if (m_pend && !m_we) dout0 = sram[m_addr];
        else                 dout0 = $urandom;
    end

    // ---------------- Transaction-level reference model --------------------
    logic [7:0]  mem_b [1024];
    int          cyc = 0, acc_cyc = -1, rsp_cyc = -1;
    bit          chk_en = 0, busy = 0;
    logic [31:0] p_rdata;
    logic        p_err;
    logic        acc_web;
    logic [3:0]  acc_mask;
    logic [7:0]  acc_addr;
    logic [31:0] acc_din;
    logic [7:0]  e_addr0;
    logic [31:0] e_din0, e_rdata;
    logic        e_err;

    always @(negedge clk) begin : model
        bit          in_acc, in_rsp, rdy_exp, mis;
        int          n, a;
        logic [63:0] v;
        cyc++;
        in_acc  = chk_en && (cyc == acc_cyc);
        in_rsp  = chk_en && busy && (cyc == rsp_cyc);
        rdy_exp = !reset && !busy;
        if (chk_en) begin
            if (in_acc) begin e_addr0 = acc_addr; e_din0 = acc_din; end
            if (in_rsp) begin e_rdata = p_rdata; e_err = p_err; end
            chk("csb0",      csb0,      in_acc ? 1'b0 : 1'b1);
            chk("web0",      web0,      in_acc ? acc_web : 1'b1);
            chk("wmask0",    wmask0,    in_acc ? acc_mask : 4'b0000);
            chk("addr0",     addr0,     e_addr0);
            chk("din0",      din0,      e_din0);
            chk("rsp_valid", rsp_valid, in_rsp);
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("rsp_err",   rsp_err,   e_err);
            chk("req_ready", req_ready, rdy_exp);
            if (in_rsp) busy = 0;
        end
        if (reset) begin
            chk_en = 1; busy = 0; acc_cyc = -1; rsp_cyc = -1;
            e_addr0 = 8'h00; e_din0 = 32'h0; e_rdata = 32'h0; e_err = 1'b0;
        end else if (chk_en && rdy_exp && req_valid) begin
            n    = 1 << req_size;
            a    = int'(req_addr);
            mis  = (req_size == 2'd3) || ((a % n) != 0);
            busy = 1;
            p_err = 1'b0; p_rdata = 32'h0;
            if (mis) begin
                p_err   = 1'b1;
                rsp_cyc = cyc + 1;
            end else begin
                acc_cyc  = cyc + 1;
                acc_addr = req_addr[9:2];
                acc_web  = !req_we;
                acc_mask = 4'b0000;
                acc_din  = 32'h0;
                if (req_we) begin
                    for (int k = 0; k < n; k++) acc_mask[(a % 4) + k] = 1'b1;
                    for (int i = 0; i < 4; i++) acc_din[8*i +: 8] = req_wdata[8*(i % n) +: 8];
                    for (int k = 0; k < n; k++) mem_b[a + k] = req_wdata[8*k +: 8];
                    rsp_cyc = cyc + 2;
                end else begin
                    v = 64'h0;
                    for (int k = 0; k < n; k++) v = v | (64'(mem_b[a + k]) << (8*k));
                    if (!req_unsigned && n < 4 && v[8*n-1]) v = v | (~64'h0 << (8*n));
                    p_rdata = v[31:0];
                    rsp_cyc = cyc + 3;
                end
            end
        end
    end

    int rsp_seen = 0;
    always @(negedge clk) if (rsp_valid === 1'b1) rsp_seen++;

    // ---------------- Driver ------------------------------------------------
    task automatic do_req(input logic we, input logic [9:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic a_csb, output logic a_web, output logic [3:0] a_mask,
                          output logic [7:0] a_addr, output logic [31:0] a_din);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready !== 1'b1 && n < 20);
        if (req_ready !== 1'b1) chk("accept_timeout", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom;
        req_size = $urandom; req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk); lat++;
            if (lat == 1) begin
                a_csb = csb0; a_web = web0; a_mask = wmask0; a_addr = addr0; a_din = din0;
            end
        end while (rsp_valid !== 1'b1 && lat < 10);
        if (rsp_valid !== 1'b1) chk("rsp_timeout", rsp_valid, 1'b1);
        rdata = rsp_rdata; err = rsp_err;
    endtask

    logic [31:0] rd, ad;
    logic        er, ac, aw;
    logic [3:0]  am;
    logic [7:0]  aa;
    int          lt, nn, base;
    time         t0, t1;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 10'h0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
        for (int w = 0; w < 256; w++) begin
            sram[w] = $urandom;
            for (int i = 0; i < 4; i++) mem_b[4*w + i] = sram[w][8*i +: 8];
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Word store then load
        do_req(1'b1, 10'h010, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, lt, ac, aw, am, aa, ad);
        chk("st_word_lat", lt, 32'd2);
        chk("st_word_csb", ac, 1'b0);
        chk("st_word_web", aw, 1'b0);
        chk("st_word_addr0", aa, 8'h04);
        chk("st_word_mask", am, 4'b1111);
        do_req(1'b0, 10'h010, 2'd2, 1'b0, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("ld_word_lat", lt, 32'd3);
        chk("ld_word_data", rd, 32'hDEADBEEF);
        chk("ld_word_err", er, 1'b0);

        // Byte store and signed/unsigned byte loads
        do_req(1'b1, 10'h013, 2'd0, 1'b0, 32'h00000080, rd, er, lt, ac, aw, am, aa, ad);
        chk("st_byte_mask", am, 4'b1000);
        chk("st_byte_din", ad, 32'h80808080);
        do_req(1'b0, 10'h013, 2'd0, 1'b0, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("ld_byte_signed", rd, 32'hFFFFFF80);
        do_req(1'b0, 10'h013, 2'd0, 1'b1, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("ld_byte_unsigned", rd, 32'h00000080);

        // Half store into a known word
        do_req(1'b1, 10'h020, 2'd2, 1'b0, 32'h12345678, rd, er, lt, ac, aw, am, aa, ad);
        do_req(1'b1, 10'h022, 2'd1, 1'b0, 32'h00008001, rd, er, lt, ac, aw, am, aa, ad);
        chk("st_half_mask", am, 4'b1100);
        chk("st_half_din", ad, 32'h80018001);
        do_req(1'b0, 10'h022, 2'd1, 1'b0, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("ld_half_signed", rd, 32'hFFFF8001);
        do_req(1'b0, 10'h020, 2'd2, 1'b0, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("ld_word_after_half", rd, 32'h80015678);

        // Misalignment and illegal size
        do_req(1'b1, 10'h004, 2'd2, 1'b0, 32'hCAFEF00D, rd, er, lt, ac, aw, am, aa, ad);
        do_req(1'b0, 10'h001, 2'd1, 1'b0, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("mis_half_err", er, 1'b1);
        chk("mis_half_lat", lt, 32'd1);
        chk("mis_half_csb", ac, 1'b1);
        chk("mis_half_rdata", rd, 32'h0);
        do_req(1'b1, 10'h006, 2'd2, 1'b0, 32'h11111111, rd, er, lt, ac, aw, am, aa, ad);
        chk("mis_word_err", er, 1'b1);
        chk("mis_word_csb", ac, 1'b1);
        do_req(1'b0, 10'h010, 2'd3, 1'b0, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("size3_err", er, 1'b1);
        chk("size3_lat", lt, 32'd1);
        do_req(1'b0, 10'h004, 2'd2, 1'b0, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("mis_mem_unchanged", rd, 32'hCAFEF00D);

        // Continuous request stream, alternating store/load
        #1 base = rsp_seen;
        for (int i = 0; i < 12; i++) begin
            req_valid = 1'b1; req_we = (i % 2 == 0); req_size = 2'd2;
            req_addr = 10'h040 + 10'(4 * (i / 2)); req_unsigned = 1'b0;
            req_wdata = $urandom;
            nn = 0;
            do begin @(negedge clk); nn++; end while (req_ready !== 1'b1 && nn < 20);
            if (req_ready !== 1'b1) chk("stream_accept_timeout", req_ready, 1'b1);
            if (i == 0) t0 = $time;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        nn = 0;
        do begin @(negedge clk); nn++; end while (rsp_valid !== 1'b1 && nn < 10);
        t1 = $time;
        chk("stream_span_cycles", 32'((t1 - t0) / 10), 32'd41);
        @(posedge clk); #1;
        chk("stream_rsp_count", rsp_seen - base, 32'd12);

        // Reset during DATA of a load
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h020; req_size = 2'd2; req_unsigned = 1'b0;
        nn = 0;
        do begin @(negedge clk); nn++; end while (req_ready !== 1'b1 && nn < 20);
        @(posedge clk); #1 req_valid = 1'b0;        // ACCESS
        @(posedge clk); #1 reset = 1'b1;            // DATA
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_csb0", csb0, 1'b1);
        chk("rst_web0", web0, 1'b1);
        chk("rst_wmask0", wmask0, 4'b0000);
        chk("rst_addr0", addr0, 8'h00);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_ready", req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("rst_no_rsp", rsp_valid, 1'b0);
            @(negedge clk);
        end
        do_req(1'b0, 10'h010, 2'd2, 1'b0, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("post_rst_load", rd, 32'h80ADBEEF);

        // Reset during ACCESS of a store: the store still lands
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h030; req_size = 2'd2;
        req_wdata = 32'h0AA55AA5;
        nn = 0;
        do begin @(negedge clk); nn++; end while (req_ready !== 1'b1 && nn < 20);
        @(posedge clk); #1 begin req_valid = 1'b0; reset = 1'b1; end
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        do_req(1'b0, 10'h030, 2'd2, 1'b0, 32'h0, rd, er, lt, ac, aw, am, aa, ad);
        chk("rst_access_store_lands", rd, 32'h0AA55AA5);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            logic [1:0] sz;
            logic [9:0] ad_r;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sz   = 2'($urandom % 4);
            ad_r = 10'($urandom % 1024);
            if ($urandom % 2 == 0) ad_r = ad_r & 10'h03F;
            if ($urandom % 5 != 0) ad_r = ad_r & (10'h3FF << sz);
            do_req(1'($urandom), ad_r, sz, 1'($urandom), $urandom, rd, er, lt, ac, aw, am, aa, ad);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_port0_master.md
# sram_port0_master

Request-side controller for port 0 (RW) of the 32x256 OpenRAM data SRAM macro. It accepts one byte-addressed load/store at a time from the core's memory stage over a valid/ready handshake. It generates the macro's active-low chip-select, write-enable and byte write mask, plus lane-replicated write data. On loads it captures `dout0`, extracts the addressed byte/half/word, sign- or zero-extends it, and returns a single-cycle response.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, SRAM word-address width
- `DATA_WIDTH`, 32, word width; fixed at 32
- `NUM_WMASKS`, 4, byte lanes; fixed at 4

Ports:
- `clk`  in  1  single clock, rising-edge; also drives the macro's `clk0`
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_WIDTH+2  byte address
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- `req_unsigned`  in  1  load zero-extends when 1
- `req_wdata`  in  32  store data, right-justified
- `rsp_valid`  out  1  one-cycle response strobe; there is no back-pressure
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  misaligned or illegal size; qualified by `rsp_valid`
- `csb0`  out  1  macro chip select, active low
- `web0`  out  1  macro write enable, active low
- `wmask0`  out  4  macro byte write mask
- `addr0`  out  ADDR_WIDTH  macro word address, equal to `req_addr[ADDR_WIDTH+1:2]`
- `din0`  out  32  macro write data
- `dout0`  in  32  macro read data

## Operation
- **State machine:** IDLE, ACCESS, DATA, RESP.
  - All macro-side outputs and response outputs are registered.
  - `req_ready` = (state == IDLE) && !reset.
- **IDLE:** on `req_valid && req_ready`, latch the request and check alignment.
  - Misaligned cases: size 1 with `addr[0]`=1; size 2 with `addr[1:0]`≠0; size 3.
  - Misaligned → RESP with `rsp_err`=1. The macro is not touched (`csb0` stays 1).
  - Aligned → ACCESS.
- **ACCESS (exactly one cycle):** `csb0`=0, `web0`=!we, and `addr0`, `wmask0`, `din0` are valid. The macro captures them at the edge that ends ACCESS.
  - Store → RESP. Load → DATA.
- **DATA:** `csb0`=1. `dout0` is valid from the falling edge within DATA through the rising edge that ends DATA. The controller samples it at that rising edge, extracts the lane, and goes to RESP.
- **RESP:** `rsp_valid`=1 for one cycle, then IDLE. `rsp_rdata` and `rsp_err` hold their values until the next response.
- **Write mask, by size:**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
  - Loads: `wmask0` = 0.
- **Write data:**
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: `wdata`.
  - `din0` = 0 when not storing.
- **Load extraction:**
  - Byte: lane `addr[1:0]`.
  - Half: lane `addr[1]`.
  - Sign-extend from bit 7 or bit 15 unless `req_unsigned`.
- **Idle outputs:** `csb0`=1, `web0`=1, `wmask0`=0. `addr0` and `din0` keep their last values, which are don't-care to the macro.

## Timing
- **Reset values:**
  - `csb0`=1, `web0`=1, `wmask0`=0, `addr0`=0, `din0`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `req_ready`=0 while `reset` is high; state = IDLE.
- **Latency from accept edge E0 to the edge that sees `rsp_valid`:**
  - Load: 3 cycles.
  - Store: 2 cycles.
  - Error: 1 cycle.
- **Throughput:** one load per 4 cycles, one store per 3 cycles. `req_ready` returns high in the cycle after RESP.
- **Requests outside IDLE:** `req_valid` in any other state is ignored; the requester must hold its request until `req_ready`.
- **Reset during a transaction:** the transaction is abandoned and no response is issued.
  - If reset is sampled at the edge ending ACCESS, the macro still sees `csb0`=0 at that edge. The access completes in the macro, so a store may land.
  - `csb0` is 1 from the following cycle.
- **Back-to-back same address:** a load issued after a store completes (RESP seen) returns the new data. The macro writes on the falling edge within DATA/RESP, so this ordering needs no hazard logic.

## Test plan
- **Word store/load:** reset, then store word `0xDEADBEEF` to byte address `0x010`.
  - Expected: ACCESS drives `addr0`=4, `wmask0`=`1111`, `web0`=0.
  - Then load word from `0x010` → `rsp_rdata`=`0xDEADBEEF` exactly 3 cycles after accept, with `rsp_err`=0.
- **Byte store and signed/unsigned loads:** store byte `0x80` to `0x013` → `wmask0`=`1000`, `din0`=`0x80808080`.
  - Signed byte load from `0x013` → `0xFFFFFF80`.
  - Unsigned byte load from `0x013` → `0x00000080`.
- **Half store and loads:** store half `0x8001` to `0x022` → `wmask0`=`1100`.
  - Signed half load → `0xFFFF8001`.
  - Word load from `0x020` → upper half `0x8001`, lower half unchanged.
- **Misalignment and illegal size:** half load at `0x001`, word store at `0x006`, and size=3.
  - Expected for each: `rsp_err`=1 one cycle after accept, `csb0` never 0, memory unchanged.
- **Handshake:** hold `req_valid` high continuously with alternating store and load.
  - Expected: `req_ready` pulses high only in IDLE, and responses appear at a 3/4-cycle cadence.
  - No request is dropped or duplicated; compare against a scoreboard.
- **Reset mid-operation:** assert `reset` for 1 cycle during DATA of a load.
  - Expected: no `rsp_valid`, and all outputs return to reset values.
  - The next request completes normally.
